// File: rtl/hazard_stall_controller_if.sv
// ID-stage hazard inputs and pipeline control strobes for the stall controller.
// The controller side uses the slave modport; the pipeline/driver side uses master.
interface hazard_stall_controller_if #(
  parameter int CNT_W = 16
);
  logic             id_valid;
  logic [4:0]       id_rs1;
  logic [4:0]       id_rs2;
  logic             id_uses_rs2;
  logic [4:0]       id_rd;
  logic             id_mem_read;
  logic             mem_branch_taken;
  logic             pc_write;
  logic             if_id_write;
  logic             if_id_flush;
  logic             id_ex_bubble;
  logic             ex_mem_flush;
  logic             ready;
  logic [CNT_W-1:0] stall_cnt;
  logic [CNT_W-1:0] flush_cnt;

  modport master (
    output id_valid, id_rs1, id_rs2, id_uses_rs2, id_rd, id_mem_read, mem_branch_taken,
    input  pc_write, if_id_write, if_id_flush, id_ex_bubble, ex_mem_flush, ready,
           stall_cnt, flush_cnt
  );

  modport slave (
    input  id_valid, id_rs1, id_rs2, id_uses_rs2, id_rd, id_mem_read, mem_branch_taken,
    output pc_write, if_id_write, if_id_flush, id_ex_bubble, ex_mem_flush, ready,
           stall_cnt, flush_cnt
  );
endinterface

// File: rtl/hazard_stall_controller.sv
// Pipeline sequencer beside ID: boot hold-off, load-use stall, taken-branch flush
// and saturating stall/flush performance counters.
//
//   state | meaning
//   BOOT  | front end held idle for START_CYCLES edges after reset
//   RUN   | normal issue; stalls on load-use, flushes on taken branch
module hazard_stall_controller #(
  parameter int START_CYCLES = 4,
  parameter int CNT_W        = 16
) (
  input  logic                         clk,
  input  logic                         reset,
  hazard_stall_controller_if.slave     bus
);

  localparam int BW = (START_CYCLES > 1) ? $clog2(START_CYCLES) : 1;
  localparam logic [BW-1:0] BOOT_LAST = BW'(START_CYCLES - 1);

  typedef enum logic {BOOT, RUN} state_t;

  state_t           state_q, state_d;
  logic [BW-1:0]    boot_cnt;
  logic             ex_load_q;
  logic [4:0]       ex_rd_q;
  logic [CNT_W-1:0] stall_cnt_q;
  logic [CNT_W-1:0] flush_cnt_q;
  logic             run;
  logic             load_use;
  logic             flush;

  assign run   = (state_q == RUN);
  assign flush = run & bus.mem_branch_taken;

  // x0 never stalls; a branch flush in the same cycle suppresses the stall
  assign load_use = run & ex_load_q & (ex_rd_q != 5'd0) & bus.id_valid &
                    ((bus.id_rs1 == ex_rd_q) | (bus.id_uses_rs2 & (bus.id_rs2 == ex_rd_q))) &
                    ~bus.mem_branch_taken;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= BOOT;
      boot_cnt <= '0;
    end else begin
      state_q <= state_d;
      if (state_q == BOOT && boot_cnt != BOOT_LAST)
        boot_cnt <= boot_cnt + 1'b1;
    end
  end

  always_comb begin
    state_d          = state_q;
    bus.pc_write     = 1'b0;
    bus.if_id_write  = 1'b0;
    bus.if_id_flush  = 1'b0;
    bus.id_ex_bubble = 1'b1;
    bus.ex_mem_flush = 1'b0;
    bus.ready        = 1'b0;
    case (state_q)
      BOOT: begin
        if (boot_cnt == BOOT_LAST)
          state_d = RUN;
      end
      RUN: begin
        bus.ready = 1'b1;
        if (flush) begin
          bus.pc_write     = 1'b1;
          bus.if_id_write  = 1'b1;
          bus.if_id_flush  = 1'b1;
          bus.ex_mem_flush = 1'b1;
        end else if (!load_use) begin
          bus.pc_write     = 1'b1;
          bus.if_id_write  = 1'b1;
          bus.id_ex_bubble = 1'b0;
        end
      end
      default: state_d = BOOT;
    endcase
  end

  // Shadow of the ID/EX load state; a bubble enters EX whenever ID does not advance
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ex_load_q <= 1'b0;
      ex_rd_q   <= 5'd0;
    end else if (!run || flush || load_use) begin
      ex_load_q <= 1'b0;
      ex_rd_q   <= 5'd0;
    end else begin
      ex_load_q <= bus.id_valid & bus.id_mem_read;
      ex_rd_q   <= bus.id_rd;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      if (load_use && stall_cnt_q != {CNT_W{1'b1}})
        stall_cnt_q <= stall_cnt_q + 1'b1;
      if (flush && flush_cnt_q != {CNT_W{1'b1}})
        flush_cnt_q <= flush_cnt_q + 1'b1;
    end
  end

  assign bus.stall_cnt = stall_cnt_q;
  assign bus.flush_cnt = flush_cnt_q;

endmodule
